// File: rtl/fetch_align_buffer_if.sv
// Fetch/decode handshake bundle for the fetch alignment buffer.
// master = the buffer itself, slave = fetch + decode environment.
interface fetch_align_buffer_if;
  logic        fetch_valid;
  logic        fetch_ready;
  logic [31:0] fetch_data;
  logic        flush;
  logic [31:0] flush_pc;
  logic        inst_valid;
  logic        decode_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_is_compressed;

  modport master (
    input  fetch_valid,
    input  fetch_data,
    input  flush,
    input  flush_pc,
    input  decode_ready,
    output fetch_ready,
    output inst_valid,
    output inst,
    output inst_pc,
    output inst_is_compressed
  );

  modport slave (
    output fetch_valid,
    output fetch_data,
    output flush,
    output flush_pc,
    output decode_ready,
    input  fetch_ready,
    input  inst_valid,
    input  inst,
    input  inst_pc,
    input  inst_is_compressed
  );
endinterface

// File: rtl/fetch_align_buffer.sv
// Halfword FIFO that re-aligns 32-bit fetch words into a mixed
// RVC / 32-bit instruction stream, one instruction per handshake.
module fetch_align_buffer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          BUF_HW   = 4
) (
  input logic                  clk,
  input logic                  reset,
  fetch_align_buffer_if.master bus
);

  logic [15:0] r_hw [BUF_HW];
  logic [2:0]  r_count;
  logic [31:0] r_head_pc;
  logic        r_drop_hw;

  logic        w_cmp;
  logic        w_valid;
  logic        w_accept;
  logic        w_consume;
  logic [2:0]  w_pop;
  logic [2:0]  w_push;
  logic [1:0]  w_wr;
  logic [15:0] w_shift  [BUF_HW];
  logic [15:0] w_hw_nxt [BUF_HW];

  // Encodings longer than 32 bits are handed to decode as 32-bit.
  assign w_cmp   = r_hw[0][1:0] != 2'b11;
  assign w_valid = w_cmp ? (r_count >= 3'd1)
                         : (r_count >= 3'd2);

  assign w_accept  = bus.fetch_valid & bus.fetch_ready;
  assign w_consume = w_valid & bus.decode_ready & ~bus.flush;

  assign w_pop  = w_consume ? (w_cmp ? 3'd1 : 3'd2) : 3'd0;
  assign w_push = w_accept ? (r_drop_hw ? 3'd1 : 3'd2) : 3'd0;

  // Push only happens with count <= 2, so the slot fits in 2 bits.
  assign w_wr = r_count[1:0] - w_pop[1:0];

  always_comb begin
    for (int i = 0; i < BUF_HW; i++) w_shift[i] = r_hw[i];
    unique case (1'b1)
      (w_pop == 3'd1): begin
        for (int i = 0; i < BUF_HW - 1; i++)
          w_shift[i] = r_hw[i+1];
      end
      (w_pop == 3'd2): begin
        for (int i = 0; i < BUF_HW - 2; i++)
          w_shift[i] = r_hw[i+2];
      end
      default: ;
    endcase
  end

  always_comb begin
    for (int i = 0; i < BUF_HW; i++) w_hw_nxt[i] = w_shift[i];
    if (w_accept) begin
      if (r_drop_hw) begin
        w_hw_nxt[w_wr] = bus.fetch_data[31:16];
      end else begin
        w_hw_nxt[w_wr]        = bus.fetch_data[15:0];
        w_hw_nxt[w_wr + 2'd1] = bus.fetch_data[31:16];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < BUF_HW; i++) r_hw[i] <= '0;
      r_count   <= '0;
      r_head_pc <= RESET_PC;
      r_drop_hw <= 1'b0;
    end else if (bus.flush) begin
      r_count   <= '0;
      r_head_pc <= bus.flush_pc;
      r_drop_hw <= bus.flush_pc[1];
    end else begin
      for (int i = 0; i < BUF_HW; i++) r_hw[i] <= w_hw_nxt[i];
      r_count   <= r_count - w_pop + w_push;
      r_head_pc <= r_head_pc + {28'd0, w_pop, 1'b0};
      if (w_accept) r_drop_hw <= 1'b0;
    end
  end

  assign bus.fetch_ready = (r_count <= 3'd2) & ~bus.flush;
  assign bus.inst_valid  = w_valid;
  assign bus.inst_pc     = r_head_pc;
  assign bus.inst        = w_cmp ? {16'h0000, r_hw[0]}
                                 : {r_hw[1], r_hw[0]};
  assign bus.inst_is_compressed = w_cmp & (r_count != 3'd0);

endmodule

// File: tb/tb_fetch_align_buffer.sv
// Bench for fetch_align_buffer: directed scenarios plus random traffic
// checked against an instruction-memory / PC-walk reference model.
module tb_fetch_align_buffer;

  localparam logic [31:0] RPC = 32'h0000_0000;
  localparam logic [31:0] A   = 32'h0051_0113;
  localparam logic [31:0] B   = 32'h4501_4505;
  localparam logic [31:0] C   = 32'h0020_0093;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  logic [15:0] mem [256];

  fetch_align_buffer_if bus ();

  fetch_align_buffer #(
    .RESET_PC(RPC),
    .BUF_HW  (4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  logic [65:0] obs_inst;
  logic [33:0] obs_hs;
  assign obs_inst = {bus.inst_valid, bus.inst_is_compressed,
                     bus.inst, bus.inst_pc};
  assign obs_hs   = {bus.inst_valid, bus.fetch_ready, bus.inst_pc};

  task automatic put(input logic v, input logic [31:0] d,
                     input logic r, input logic f,
                     input logic [31:0] fp);
    bus.fetch_valid  = v;
    bus.fetch_data   = d;
    bus.decode_ready = r;
    bus.flush        = f;
    bus.flush_pc     = fp;
    #1;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic r);
    put(1'b0, 32'h0, r, 1'b0, 32'h0);
  endtask

  task automatic apply_reset;
    reset = 1'b1;
    idle(1'b0);
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset;
    apply_reset();
    idle(1'b0);
    checks++;
    if (obs_hs !== {1'b0, 1'b1, RPC}) begin
      errors++;
      $display("FAIL reset_hs: got %h want %h", obs_hs, {1'b0, 1'b1, RPC});
    end
    checks++;
    if (obs_inst !== {1'b0, 1'b0, 32'h0, RPC}) begin
      errors++;
      $display("FAIL reset_inst: got %h want %h", obs_inst,
               {1'b0, 1'b0, 32'h0, RPC});
    end
  endtask

  task automatic test_addi;
    apply_reset();
    put(1'b1, A, 1'b0, 1'b0, 32'h0);
    checks++;
    if (obs_hs !== {1'b0, 1'b1, 32'h0}) begin
      errors++;
      $display("FAIL addi_pre: got %h want %h", obs_hs, {1'b0, 1'b1, 32'h0});
    end
    tick();
    idle(1'b1);
    checks++;
    if (obs_inst !== {1'b1, 1'b0, A, 32'h0}) begin
      errors++;
      $display("FAIL addi_inst: got %h want %h", obs_inst,
               {1'b1, 1'b0, A, 32'h0});
    end
    tick();
    checks++;
    if (obs_hs !== {1'b0, 1'b1, 32'h4}) begin
      errors++;
      $display("FAIL addi_drain: got %h want %h", obs_hs, {1'b0, 1'b1, 32'h4});
    end
  endtask

  task automatic test_rvc_pair;
    apply_reset();
    put(1'b1, B, 1'b0, 1'b0, 32'h0);
    tick();
    idle(1'b1);
    checks++;
    if (obs_inst !== {1'b1, 1'b1, 32'h4505, 32'h0}) begin
      errors++;
      $display("FAIL rvc0: got %h want %h", obs_inst,
               {1'b1, 1'b1, 32'h4505, 32'h0});
    end
    tick();
    checks++;
    if (obs_inst !== {1'b1, 1'b1, 32'h4501, 32'h2}) begin
      errors++;
      $display("FAIL rvc1: got %h want %h", obs_inst,
               {1'b1, 1'b1, 32'h4501, 32'h2});
    end
    tick();
    checks++;
    if (obs_hs !== {1'b0, 1'b1, 32'h4}) begin
      errors++;
      $display("FAIL rvc_drain: got %h want %h", obs_hs, {1'b0, 1'b1, 32'h4});
    end
  endtask

  task automatic test_straddle;
    apply_reset();
    put(1'b1, 32'h0113_4505, 1'b1, 1'b0, 32'h0);
    tick();
    idle(1'b1);
    checks++;
    if (obs_inst !== {1'b1, 1'b1, 32'h4505, 32'h0}) begin
      errors++;
      $display("FAIL str_c0: got %h want %h", obs_inst,
               {1'b1, 1'b1, 32'h4505, 32'h0});
    end
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++;
      if (obs_hs !== {1'b0, 1'b1, 32'h2}) begin
        errors++;
        $display("FAIL str_wait%0d: got %h want %h", k, obs_hs,
                 {1'b0, 1'b1, 32'h2});
      end
    end
    put(1'b1, 32'h4501_0051, 1'b1, 1'b0, 32'h0);
    checks++;
    if (obs_hs !== {1'b0, 1'b1, 32'h2}) begin
      errors++;
      $display("FAIL str_nocomb: got %h want %h", obs_hs, {1'b0, 1'b1, 32'h2});
    end
    tick();
    idle(1'b1);
    checks++;
    if (obs_inst !== {1'b1, 1'b0, A, 32'h2}) begin
      errors++;
      $display("FAIL str_i32: got %h want %h", obs_inst,
               {1'b1, 1'b0, A, 32'h2});
    end
    tick();
    checks++;
    if (obs_inst !== {1'b1, 1'b1, 32'h4501, 32'h6}) begin
      errors++;
      $display("FAIL str_c1: got %h want %h", obs_inst,
               {1'b1, 1'b1, 32'h4501, 32'h6});
    end
    tick();
    checks++;
    if (obs_hs !== {1'b0, 1'b1, 32'h8}) begin
      errors++;
      $display("FAIL str_drain: got %h want %h", obs_hs, {1'b0, 1'b1, 32'h8});
    end
  endtask

  task automatic test_backpressure;
    logic [65:0] exp [3];
    exp[0] = {1'b1, 1'b1, 32'h4505, 32'h4};
    exp[1] = {1'b1, 1'b1, 32'h4501, 32'h6};
    exp[2] = {1'b1, 1'b0, C, 32'h8};
    apply_reset();
    put(1'b1, A, 1'b0, 1'b0, 32'h0);
    tick();
    put(1'b1, B, 1'b0, 1'b0, 32'h0);
    checks++;
    if (obs_hs !== {1'b1, 1'b1, 32'h0}) begin
      errors++;
      $display("FAIL bp_second: got %h want %h", obs_hs, {1'b1, 1'b1, 32'h0});
    end
    tick();
    put(1'b1, C, 1'b0, 1'b0, 32'h0);
    checks++;
    if (obs_hs !== {1'b1, 1'b0, 32'h0}) begin
      errors++;
      $display("FAIL bp_full: got %h want %h", obs_hs, {1'b1, 1'b0, 32'h0});
    end
    tick();
    put(1'b1, C, 1'b1, 1'b0, 32'h0);
    checks++;
    if (obs_hs !== {1'b1, 1'b0, 32'h0}) begin
      errors++;
      $display("FAIL bp_held: got %h want %h", obs_hs, {1'b1, 1'b0, 32'h0});
    end
    checks++;
    if (obs_inst !== {1'b1, 1'b0, A, 32'h0}) begin
      errors++;
      $display("FAIL bp_a: got %h want %h", obs_inst, {1'b1, 1'b0, A, 32'h0});
    end
    tick();
    put(1'b1, C, 1'b0, 1'b0, 32'h0);
    checks++;
    if (obs_hs !== {1'b1, 1'b1, 32'h4}) begin
      errors++;
      $display("FAIL bp_reopen: got %h want %h", obs_hs, {1'b1, 1'b1, 32'h4});
    end
    tick();
    idle(1'b1);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (obs_inst !== exp[k]) begin
        errors++;
        $display("FAIL bp_drain%0d: got %h want %h", k, obs_inst, exp[k]);
      end
      tick();
    end
    checks++;
    if (obs_hs !== {1'b0, 1'b1, 32'hC}) begin
      errors++;
      $display("FAIL bp_end: got %h want %h", obs_hs, {1'b0, 1'b1, 32'hC});
    end
  endtask

  task automatic test_flush;
    apply_reset();
    put(1'b1, B, 1'b0, 1'b0, 32'h0);
    tick();
    put(1'b1, A, 1'b1, 1'b0, 32'h0);
    tick();
    put(1'b1, C, 1'b1, 1'b1, 32'h0000_0102);
    checks++;
    if (obs_hs !== {1'b1, 1'b0, 32'h2}) begin
      errors++;
      $display("FAIL fl_reject: got %h want %h", obs_hs, {1'b1, 1'b0, 32'h2});
    end
    tick();
    put(1'b1, 32'h4505_FFFF, 1'b0, 1'b0, 32'h0);
    checks++;
    if (obs_hs !== {1'b0, 1'b1, 32'h102}) begin
      errors++;
      $display("FAIL fl_target: got %h want %h", obs_hs,
               {1'b0, 1'b1, 32'h102});
    end
    tick();
    idle(1'b1);
    checks++;
    if (obs_inst !== {1'b1, 1'b1, 32'h4505, 32'h102}) begin
      errors++;
      $display("FAIL fl_upper: got %h want %h", obs_inst,
               {1'b1, 1'b1, 32'h4505, 32'h102});
    end
    tick();
    checks++;
    if (obs_hs !== {1'b0, 1'b1, 32'h104}) begin
      errors++;
      $display("FAIL fl_drain: got %h want %h", obs_hs,
               {1'b0, 1'b1, 32'h104});
    end
  endtask

  task automatic test_reset_mid;
    apply_reset();
    put(1'b1, A, 1'b0, 1'b0, 32'h0);
    tick();
    idle(1'b0);
    checks++;
    if (obs_hs !== {1'b1, 1'b1, 32'h0}) begin
      errors++;
      $display("FAIL rm_pre: got %h want %h", obs_hs, {1'b1, 1'b1, 32'h0});
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (obs_hs !== {1'b0, 1'b1, RPC}) begin
      errors++;
      $display("FAIL rm_hs: got %h want %h", obs_hs, {1'b0, 1'b1, RPC});
    end
    checks++;
    if (obs_inst !== {1'b0, 1'b0, 32'h0, RPC}) begin
      errors++;
      $display("FAIL rm_inst: got %h want %h", obs_inst,
               {1'b0, 1'b0, 32'h0, RPC});
    end
  endtask

  // Model: fetched bytes beyond the PC decide what decode may see.
  task automatic test_random;
    logic [31:0] pc, fa, fp, d, ei;
    logic        v, r, f, pend, ev, er, ec;
    logic [15:0] h0;
    int          avail, need, done;
    for (int i = 0; i < 256; i++) begin
      mem[i] = 16'($urandom);
      if ($urandom_range(1, 0) == 1) mem[i][1:0] = 2'b11;
    end
    apply_reset();
    pc   = RPC;
    fa   = RPC & ~32'h3;
    pend = 1'b0;
    done = 0;
    for (int c = 0; c < 3000; c++) begin
      v  = pend | ($urandom_range(3, 0) != 0);
      r  = ($urandom_range(2, 0) != 0);
      f  = ($urandom_range(39, 0) == 0);
      fp = {23'd0, 8'($urandom), 1'b0};
      d  = {mem[8'((fa >> 1) + 1)], mem[8'(fa >> 1)]};
      put(v, d, r, f, fp);
      avail = int'(fa - pc);
      avail = (avail <= 0) ? 0 : avail / 2;
      h0    = mem[8'(pc >> 1)];
      ec    = (h0[1:0] != 2'b11);
      need  = ec ? 1 : 2;
      ev    = (avail >= need);
      er    = (avail <= 2) && !f;
      ei    = ec ? {16'h0, h0} : {mem[8'((pc >> 1) + 1)], h0};
      checks++;
      if (obs_hs !== {ev, er, pc}) begin
        errors++;
        $display("FAIL rnd_hs c%0d: got %h want %h", c, obs_hs, {ev, er, pc});
      end
      if (ev) begin
        checks++;
        if (obs_inst !== {1'b1, ec, ei, pc}) begin
          errors++;
          $display("FAIL rnd_inst c%0d: got %h want %h", c, obs_inst,
                   {1'b1, ec, ei, pc});
        end
      end
      if (f) begin
        pc   = fp;
        fa   = fp & ~32'h3;
        pend = 1'b0;
      end else begin
        if (v && er) fa = fa + 32'd4;
        if (ev && r) begin
          pc   = pc + 32'(need * 2);
          done = done + 1;
        end
        pend = v && !er;
      end
      tick();
    end
    checks++;
    if (done < 500) begin
      errors++;
      $display("FAIL rnd_progress: got %0d insts want >= 500", done);
    end
  endtask

  initial begin
    reset = 1'b0;
    idle(1'b0);
    test_reset();
    test_addi();
    test_rvc_pair();
    test_straddle();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_align_buffer.md
Name: fetch_align_buffer

Overview:
- Producer side of the decode interface. Accepts 32-bit word-aligned fetch words and re-aligns a mixed 16-bit (RVC) / 32-bit instruction stream.
- Presents one complete instruction per handshake to the decode stage, with its PC and a compressed flag.
- Sits between instruction memory/fetch and the IF/ID register.
- Handles halfword-aligned redirect targets and 32-bit instructions that straddle word boundaries.

Parameters:
- RESET_PC, 32'h0000_0000, PC of the first instruction after reset.
- BUF_HW, 4, buffer depth in 16-bit halfwords (fixed at 4; other values unsupported).

Ports:
- clk  input  1  core clock
- reset  input  1  synchronous, active-high reset
- fetch_valid  input  1  fetch_data holds the next sequential fetch word
- fetch_ready  output  1  buffer can accept a word this cycle
- fetch_data  input  32  word at address (expected_pc & ~3); halfword 0 = bits[15:0]
- flush  input  1  redirect (branch/jump/trap); highest priority
- flush_pc  input  32  redirect target, bit0 = 0, bit1 may be 1
- inst_valid  output  1  complete instruction at buffer head
- decode_ready  input  1  decode consumes inst this cycle
- inst  output  32  instruction; compressed ones zero-extended in [31:16]
- inst_pc  output  32  PC of inst
- inst_is_compressed  output  1  head halfword bits[1:0] != 2'b11

Behaviour:
- Storage:
  - 4 x 16-bit halfword FIFO, with count_q in 0..4.
  - head_pc_q: PC of the head halfword.
  - drop_hw_q: discard lower halfword of next accepted word.
- Reset (synchronous): count_q = 0, head_pc_q = RESET_PC, drop_hw_q = 0.
- Output values in reset: inst_valid = 0, fetch_ready = 1, inst = 0, inst_is_compressed = 0, inst_pc = RESET_PC.
- fetch_ready = (count_q <= 2) & ~flush. Accept = fetch_valid & fetch_ready.
- Accepted word push:
  - drop_hw_q = 0: push both halfwords (low first), count += 2.
  - drop_hw_q = 1: push only the upper halfword, count += 1, clear drop_hw_q.
- Head decode (combinational from registered state):
  - head[1:0] != 2'b11: compressed. inst_valid = (count_q >= 1); inst = {16'h0, hw0}; consume size 1.
  - else: 32-bit. inst_valid = (count_q >= 2); inst = {hw1, hw0}; consume size 2.
  - inst_pc = head_pc_q.
  - When inst_valid = 0, inst and inst_is_compressed hold the head-derived value. The bench must not check them.
- Consume = inst_valid & decode_ready & ~flush:
  - Pop 1 or 2 halfwords.
  - head_pc_q += 2 (compressed) or 4 (32-bit); wraps modulo 2^32.
- Push and pop in the same cycle are both performed. new count = count - pop + push.
  - Never exceeds 4, since push requires count <= 2 beforehand.
- Latency: a word accepted in cycle N is visible on inst_valid in N+1. There is no combinational path fetch_valid -> inst_valid.
- Straddling 32-bit instruction (low half is the last halfword of a word): inst_valid stays 0 until the next word is accepted, then asserts the following cycle.
- Flush (overrides everything that cycle):
  - count_q <= 0, head_pc_q <= flush_pc, drop_hw_q <= flush_pc[1].
  - Concurrent fetch word is not accepted (fetch_ready = 0).
  - Concurrent handshake is not counted as a consume.
  - Fetch must restart at flush_pc & ~3.
- Flush during straddle: the partial low half is discarded.
- fetch_valid while fetch_ready = 0: the word is not taken. The fetch stage holds it (valid/ready, no drop).
- Instruction-length encodings > 32 bits (bits[4:2] = 3'b111 with [1:0] = 11) are treated as 32-bit. Illegal-instruction detection belongs to decode.
- No internal overflow or underflow states. The full condition (count_q = 3 or 4) only deasserts fetch_ready.

Test Plan:
- Reset, then one word 32'h0051_0113 (addi) at RESET_PC = 0 -> inst_valid next cycle, inst = 32'h0051_0113, inst_pc = 0, inst_is_compressed = 0, count back to 0 after consume.
- Word 32'h4501_4505 (c.li a0,1 ; c.li a0,0) -> two handshakes: inst = 32'h0000_4505 @ pc 0, then 32'h0000_4501 @ pc 2, both compressed.
- Straddle:
  - Stimulus: word0 = {16'h0113 (low of addi), 16'h4505}, then word1 = {16'h4501, 16'h0051}.
  - Outputs: c.li @0; then inst_valid = 0 until word1 accepted; then 32'h0051_0113 @2 compressed = 0; then 32'h0000_4501 @6.
- Backpressure: decode_ready = 0 with 3 words offered -> fetch_ready drops after two words (count = 4). Third word accepted only after a consume. No instruction lost or duplicated.
- Flush to 32'h0000_0102 while count = 3 and fetch_valid = 1 -> same-cycle word rejected. Next word 32'h4505_FFFF -> only upper half kept: inst = 32'h0000_4505 @ 32'h102.
- Reset asserted mid-stream (count = 2, inst_valid = 1) -> next cycle inst_valid = 0, fetch_ready = 1, inst_pc = RESET_PC.
